cache_main_mem: RTL

- Backing main-memory model/controller directly downstream of dm_cache_fsm.
- Consumes the cache's block-granular mem_req (read-fill or write-back) and returns a block with a ready pulse after a fixed, parameterised latency.
- Synthesizable single-ported block store. Holds one outstanding request at a time, matching the cache FSM's blocking miss handling.

---
 rtl/cache_pkg.sv | 36 +++
 rtl/cache_mem_array.sv | 35 +++
 rtl/cache_main_mem.sv | 109 ++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped cache and its backing main memory.
package cache_pkg;

  localparam int CACHE_ADDR_W    = 32;
  localparam int CACHE_BLOCK_W   = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = CACHE_BLOCK_W / WORD_W;
  localparam int BYTES_PER_WORD  = WORD_W / 8;
  localparam int BYTES_PER_BLOCK = CACHE_BLOCK_W / 8;
  localparam int LAT_CNT_W       = 4;

  typedef struct packed {
    logic [CACHE_BLOCK_W-1:0] data;
    logic [CACHE_ADDR_W-1:0]  addr;
    logic                     rw;
    logic                     valid;
  } mem_req_t;

  typedef struct packed {
    logic [CACHE_BLOCK_W-1:0] data;
    logic                     ready;
  } mem_data_t;

  typedef enum logic [1:0] {
    MM_IDLE    = 2'd0,
    MM_WAIT    = 2'd1,
    MM_RESP    = 2'd2,
    MM_RECOVER = 2'd3
  } mm_state_e;

  // Power-on contents: every word holds its own byte address.
  function automatic logic [WORD_W-1:0] init_word(input int blk, input int wrd);
    return WORD_W'(blk * BYTES_PER_BLOCK + wrd * BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Single-port block store; reset reloads every word with its own byte address.
module cache_mem_array
  import cache_pkg::*;
#(
  parameter int BLOCK_W    = CACHE_BLOCK_W,
  parameter int NUM_BLOCKS = 256,
  parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  input  logic               we,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);

  localparam int WORDS = BLOCK_W / WORD_W;

  logic [BLOCK_W-1:0] mem_q [NUM_BLOCKS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        for (int w = 0; w < WORDS; w++) begin
          mem_q[i][w*WORD_W +: WORD_W] <= init_word(i, w);
        end
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/cache_main_mem.sv
// Main-memory controller behind dm_cache_fsm: one blocking block read/write with fixed latency.
module cache_main_mem
  import cache_pkg::*;
#(
  parameter int ADDR_W     = CACHE_ADDR_W,
  parameter int BLOCK_W    = CACHE_BLOCK_W,
  parameter int NUM_BLOCKS = 256,
  parameter int LATENCY    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_valid,
  input  logic               mem_req_rw,
  input  logic [ADDR_W-1:0]  mem_req_addr,
  input  logic [BLOCK_W-1:0] mem_req_data,
  output logic               mem_data_ready,
  output logic [BLOCK_W-1:0] mem_data_data,
  output logic               mem_busy
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int OFF_W = $clog2(BLOCK_W / 8);
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

  mm_state_e              state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   rw_q, rw_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BLOCK_W-1:0]     wdata_q, wdata_d;

  logic [IDX_W-1:0]       req_idx;
  logic [BLOCK_W-1:0]     arr_rdata;
  logic                   arr_we;
  logic                   unused_addr_bits;

  // Upper address bits are dropped so addresses alias modulo the array size.
  assign req_idx          = mem_req_addr[IDX_W+OFF_W-1:OFF_W];
  assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:IDX_W+OFF_W], mem_req_addr[OFF_W-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MM_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      MM_IDLE: begin
        if (mem_req_valid) begin
          rw_d    = mem_req_rw;
          idx_d   = req_idx;
          wdata_d = mem_req_data;
          cnt_d   = CNT_LOAD;
          state_d = MM_WAIT;
        end
      end
      MM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MM_RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      MM_RESP:    state_d = MM_RECOVER;
      // Valid may still be high from the request just served; skip one cycle.
      MM_RECOVER: state_d = MM_IDLE;
      default:    state_d = MM_IDLE;
    endcase
  end

  always_comb begin
    mem_busy       = (state_q != MM_IDLE);
    mem_data_ready = (state_q == MM_RESP);
    arr_we         = (state_q == MM_RESP) && rw_q;
    mem_data_data  = '0;
    if (state_q == MM_RESP) begin
      mem_data_data = rw_q ? wdata_q : arr_rdata;
    end
  end

  cache_mem_array #(
    .BLOCK_W    (BLOCK_W),
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .idx   (idx_q),
    .we    (arr_we),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule
